// File: rtl/seg2bcd_scan.sv
// Samples a multiplexed 7-segment display bus and decodes it back into hex digits.
// Optional macro SEG_BLANK_EN: treat the all-segments-off pattern as a legal blank digit.
module seg2bcd_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter bit Active_High    = 1'b0,
    parameter bit AN_Active_High = 1'b0,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    CA,
    input  logic                    CB,
    input  logic                    CC,
    input  logic                    CD,
    input  logic                    CE,
    input  logic                    CF,
    input  logic                    CG,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    code_err
`ifdef SEG_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank
`endif
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    // Returns {hit, code} for an active-low CA..CG pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic int onehot_index(input logic [NUM_DIGITS-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    logic [SW-1:0]         sync_p0;
    logic [SW-1:0]         sync_p1;
    logic [SW-1:0]         sync_p2;
    logic [CW-1:0]         cnt;
    logic                  armed;
    logic [NUM_DIGITS-1:0] mask;

    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] sel;
    logic                  same;
    logic                  capture;
    logic                  onehot;
    logic [4:0]            dec;
    logic                  is_blank;
    logic                  legal;
    logic [NUM_DIGITS-1:0] mask_next;
    logic                  frame_done;
    int                    idx;

    // sync_p1 is the synchronized sample; sync_p2 holds it one cycle later, so when
    // a capture fires sync_p2 is guaranteed to be the pattern that was stable.
    always_comb begin
        seg_n      = Active_High ? ~sync_p2[6:0] : sync_p2[6:0];
        sel        = AN_Active_High ? sync_p2[SW-1:7] : ~sync_p2[SW-1:7];
        same       = (sync_p1 == sync_p2);
        capture    = armed && (cnt == CW'(STABLE_CYCLES));
        onehot     = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        dec        = seg_decode(seg_n);
`ifdef SEG_BLANK_EN
        is_blank   = (seg_n == 7'b1111111);
`else
        is_blank   = 1'b0;
`endif
        legal      = dec[4] || is_blank;
        mask_next  = mask | sel;
        frame_done = &mask_next;
        idx        = onehot_index(sel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            sync_p2     <= '0;
            cnt         <= '0;
            armed       <= 1'b1;
            mask        <= '0;
            value       <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
`ifdef SEG_BLANK_EN
            blank       <= '0;
`endif
        end else begin
            sync_p0     <= {an, CA, CB, CC, CD, CE, CF, CG};
            sync_p1     <= sync_p0;
            sync_p2     <= sync_p1;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;

            if (same) begin
                if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
            end else begin
                cnt <= CW'(1);
            end

            if (!same)        armed <= 1'b1;
            else if (capture) armed <= 1'b0;

            if (capture && onehot) begin
                if (legal) begin
                    digit_valid[idx] <= 1'b1;
                    if (dec[4]) value[4*idx +: 4] <= dec[3:0];
`ifdef SEG_BLANK_EN
                    blank[idx] <= is_blank;
`endif
                    if (frame_done) begin
                        frame_valid <= 1'b1;
                        mask        <= '0;
                    end else begin
                        mask <= mask_next;
                    end
                end else begin
                    code_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg2bcd_scan.sv
// Directed bench for seg2bcd_scan: default-polarity instance plus an active-high instance.
module tb_seg2bcd_scan;

    logic        clk;
    logic        rst_n;
    logic        CA, CB, CC, CD, CE, CF, CG;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        code_err;

    logic        CA2, CB2, CC2, CD2, CE2, CF2, CG2;
    logic [3:0]  an2;
    logic [15:0] value2;
    logic [3:0]  digit_valid2;
    logic        frame_valid2;
    logic        code_err2;
`ifdef SEG_BLANK_EN
    logic [3:0]  blank;
    logic [3:0]  blank2;
`endif

    int nvec = 0;
    int nerr = 0;
    int fv_cnt = 0;
    int ce_cnt = 0;
    int ce2_cnt = 0;

    seg2bcd_scan #(.NUM_DIGITS(4), .Active_High(1'b0), .AN_Active_High(1'b0), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
        .an(an), .value(value), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .code_err(code_err)
`ifdef SEG_BLANK_EN
        , .blank(blank)
`endif
    );

    seg2bcd_scan #(.NUM_DIGITS(4), .Active_High(1'b1), .AN_Active_High(1'b1), .STABLE_CYCLES(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .CA(CA2), .CB(CB2), .CC(CC2), .CD(CD2), .CE(CE2), .CF(CF2), .CG(CG2),
        .an(an2), .value(value2), .digit_valid(digit_valid2),
        .frame_valid(frame_valid2), .code_err(code_err2)
`ifdef SEG_BLANK_EN
        , .blank(blank2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_bus(input logic [3:0] a, input logic [6:0] s);
        an = a;
        {CA, CB, CC, CD, CE, CF, CG} = s;
    endtask

    task automatic set_bus2(input logic [3:0] a, input logic [6:0] s);
        an2 = a;
        {CA2, CB2, CC2, CD2, CE2, CF2, CG2} = s;
    endtask

    // Advance n clock edges, tallying output pulses at each falling edge.
    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            if (frame_valid) fv_cnt++;
            if (code_err)    ce_cnt++;
            if (code_err2)   ce2_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_bus(4'b1110, 7'b1001111);
        hold(1);
        set_bus(4'b1101, 7'b0010010);
        hold(1);
        nvec++; if (value !== 16'h0000) begin nerr++; $display("FAIL reset_value got=%h exp=0000", value); end
        nvec++; if (digit_valid !== 4'b0000) begin nerr++; $display("FAIL reset_dv got=%b exp=0000", digit_valid); end
        nvec++; if (fv_cnt != 0 || ce_cnt != 0) begin nerr++; $display("FAIL reset_pulses fv=%0d ce=%0d exp=0,0", fv_cnt, ce_cnt); end
        rst_n = 1'b1;
        set_bus(4'b1110, 7'b1001111);
        hold(6);
        nvec++; if (digit_valid !== 4'b0000) begin nerr++; $display("FAIL reset_early_capture dv=%b exp=0000", digit_valid); end
        hold(1);
        nvec++; if (value !== 16'h0001 || digit_valid !== 4'b0001) begin
            nerr++; $display("FAIL reset_first_capture value=%h dv=%b exp=0001/0001", value, digit_valid); end
        set_bus(4'b1101, 7'b0010010);
        hold(4);
        rst_n = 1'b0;
        hold(1);
        nvec++; if (value !== 16'h0000 || digit_valid !== 4'b0000) begin
            nerr++; $display("FAIL reset_mid value=%h dv=%b exp=0000/0000", value, digit_valid); end
        rst_n = 1'b1;
        hold(6);
        nvec++; if (value !== 16'h0000) begin nerr++; $display("FAIL reset_mid_early value=%h exp=0000", value); end
        hold(1);
        nvec++; if (value !== 16'h0020 || digit_valid !== 4'b0010) begin
            nerr++; $display("FAIL reset_mid_capture value=%h dv=%b exp=0020/0010", value, digit_valid); end
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int fv0, ce0;
        fv0 = fv_cnt; ce0 = ce_cnt;
        set_bus(4'b1110, 7'b1001111); hold(8);
        set_bus(4'b1101, 7'b0010010); hold(8);
        set_bus(4'b1011, 7'b0000110); hold(8);
        nvec++; if (fv_cnt != fv0) begin nerr++; $display("FAIL scan_early_frame got=%0d exp=%0d", fv_cnt, fv0); end
        set_bus(4'b0111, 7'b1001100); hold(8);
        nvec++; if (fv_cnt != fv0 + 1) begin nerr++; $display("FAIL scan_frame got=%0d exp=%0d", fv_cnt, fv0 + 1); end
        nvec++; if (value !== 16'h4321) begin nerr++; $display("FAIL scan_value got=%h exp=4321", value); end
        nvec++; if (digit_valid !== 4'b1111) begin nerr++; $display("FAIL scan_dv got=%b exp=1111", digit_valid); end
        nvec++; if (ce_cnt != ce0) begin nerr++; $display("FAIL scan_code_err got=%0d exp=%0d", ce_cnt, ce0); end
    endtask

    task automatic test_glitch();
        int ce0;
        ce0 = ce_cnt;
        set_bus(4'b1110, 7'b0001111); hold(3);
        set_bus(4'b1110, 7'b0000000); hold(1);
        set_bus(4'b1110, 7'b0001111); hold(6);
        nvec++; if (value[3:0] !== 4'h1) begin nerr++; $display("FAIL glitch_early got=%h exp=1", value[3:0]); end
        hold(1);
        nvec++; if (value[3:0] !== 4'h7) begin nerr++; $display("FAIL glitch_capture got=%h exp=7", value[3:0]); end
        hold(8);
        nvec++; if (value !== 16'h4327 || ce_cnt != ce0) begin
            nerr++; $display("FAIL glitch_final value=%h ce=%0d exp=4327/%0d", value, ce_cnt, ce0); end
    endtask

    task automatic test_illegal();
        int ce0, fv0;
        ce0 = ce_cnt; fv0 = fv_cnt;
        set_bus(4'b1110, 7'b1111110); hold(20);
        nvec++; if (ce_cnt != ce0 + 1) begin nerr++; $display("FAIL illegal_err got=%0d exp=%0d", ce_cnt, ce0 + 1); end
        nvec++; if (value[3:0] !== 4'h7 || digit_valid[0] !== 1'b1) begin
            nerr++; $display("FAIL illegal_state nib=%h dv0=%b exp=7/1", value[3:0], digit_valid[0]); end
        nvec++; if (fv_cnt != fv0) begin nerr++; $display("FAIL illegal_frame got=%0d exp=%0d", fv_cnt, fv0); end
    endtask

    task automatic test_all_off();
        int ce0;
        ce0 = ce_cnt;
        set_bus(4'b1110, 7'b1111111); hold(12);
`ifdef SEG_BLANK_EN
        nvec++; if (blank[0] !== 1'b1 || ce_cnt != ce0) begin
            nerr++; $display("FAIL blank_set blank0=%b ce=%0d exp=1/%0d", blank[0], ce_cnt, ce0); end
`else
        nvec++; if (ce_cnt != ce0 + 1) begin nerr++; $display("FAIL alloff_err got=%0d exp=%0d", ce_cnt, ce0 + 1); end
`endif
        nvec++; if (value[3:0] !== 4'h7) begin nerr++; $display("FAIL alloff_nibble got=%h exp=7", value[3:0]); end
        set_bus(4'b1110, 7'b0000100); hold(10);
        nvec++; if (value[3:0] !== 4'h9) begin nerr++; $display("FAIL alloff_recover got=%h exp=9", value[3:0]); end
`ifdef SEG_BLANK_EN
        nvec++; if (blank[0] !== 1'b0) begin nerr++; $display("FAIL blank_clear got=%b exp=0", blank[0]); end
`endif
    endtask

    task automatic test_non_onehot();
        int ce0, fv0;
        ce0 = ce_cnt; fv0 = fv_cnt;
        set_bus(4'b1100, 7'b0100100); hold(10);
        set_bus(4'b1111, 7'b0100100); hold(10);
        set_bus(4'b0000, 7'b0100100); hold(10);
        nvec++; if (value !== 16'h4329) begin nerr++; $display("FAIL nonhot_value got=%h exp=4329", value); end
        nvec++; if (ce_cnt != ce0 || fv_cnt != fv0) begin
            nerr++; $display("FAIL nonhot_pulses ce=%0d fv=%0d exp=%0d/%0d", ce_cnt, fv_cnt, ce0, fv0); end
    endtask

    task automatic test_back_to_back();
        int fv0;
        fv0 = fv_cnt;
        set_bus(4'b1110, 7'b0000001); hold(8);
        set_bus(4'b1101, 7'b0001000); hold(8);
        set_bus(4'b1011, 7'b1100000); hold(8);
        nvec++; if (fv_cnt != fv0) begin nerr++; $display("FAIL recapture_no_frame got=%0d exp=%0d", fv_cnt, fv0); end
        set_bus(4'b0111, 7'b0111000); hold(8);
        nvec++; if (fv_cnt != fv0 + 1) begin nerr++; $display("FAIL recapture_frame got=%0d exp=%0d", fv_cnt, fv0 + 1); end
        nvec++; if (value !== 16'hFBA0) begin nerr++; $display("FAIL recapture_value got=%h exp=FBA0", value); end
    endtask

    task automatic test_polarity();
        set_bus2(4'b0001, 7'b1110111); hold(8);
        nvec++; if (value2[3:0] !== 4'hA) begin nerr++; $display("FAIL pol_digit0 got=%h exp=A", value2[3:0]); end
        set_bus2(4'b0010, 7'b0110000); hold(8);
        nvec++; if (value2 !== 16'h001A || digit_valid2 !== 4'b0011) begin
            nerr++; $display("FAIL pol_value value=%h dv=%b exp=001A/0011", value2, digit_valid2); end
        set_bus2(4'b0001, 7'b0000000); hold(10);
`ifdef SEG_BLANK_EN
        nvec++; if (blank2[0] !== 1'b1 || ce2_cnt != 0) begin
            nerr++; $display("FAIL pol_blank blank0=%b ce=%0d exp=1/0", blank2[0], ce2_cnt); end
`else
        nvec++; if (ce2_cnt != 1) begin nerr++; $display("FAIL pol_alloff_err got=%0d exp=1", ce2_cnt); end
`endif
        nvec++; if (value2 !== 16'h001A) begin nerr++; $display("FAIL pol_hold got=%h exp=001A", value2); end
    endtask

    initial begin
        rst_n = 1'b0;
        set_bus(4'b1111, 7'b1111111);
        set_bus2(4'b0000, 7'b0000000);
        test_reset();
        test_scan();
        test_glitch();
        test_illegal();
        test_all_off();
        test_non_onehot();
        test_back_to_back();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
